// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and bank address helper for the FIR tap MAC.
package fir_pkg;

    localparam int FIR_DATA_W   = 20;
    localparam int FIR_COEF_W   = 16;
    localparam int FIR_ACC_W    = 48;
    localparam int FIR_MAX_ROWS = 32;
    localparam int FIR_OUT_W    = 24;
    localparam int FIR_SHIFT    = 0;
    localparam int FIR_NBANKS   = 8;
    localparam int FIR_STAGES   = 3;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        OUT
    } state_t;

    // Bank b serves lane j=(head-b)&7 of row r: sample (head-8r-j) mod 2048, word idx[10:3].
    function automatic logic [7:0] bank_addr(
        input logic [10:0] head,
        input logic [4:0]  r,
        input logic [2:0]  b
    );
        logic [2:0]  j;
        logic [10:0] idx;
        j   = head[2:0] - b;
        idx = head - {3'b000, r, 3'b000} - {8'd0, j};
        return idx[10:3];
    endfunction

endpackage

// File: rtl/fir_adder_tree8.sv
// Registered 8-input signed adder tree; inputs are sign-extended to SUM_W, 1-cycle latency.
module fir_adder_tree8
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_DATA_W + FIR_COEF_W,
    parameter int SUM_W = FIR_ACC_W
) (
    input  logic                               i_clk,
    input  logic [FIR_NBANKS-1:0][IN_W-1:0]    i_d,
    output logic signed [SUM_W-1:0]            o_sum
);

    logic signed [SUM_W-1:0] w_l0 [FIR_NBANKS];
    logic signed [SUM_W-1:0] w_l1 [FIR_NBANKS/2];
    logic signed [SUM_W-1:0] w_l2 [FIR_NBANKS/4];

    for (genvar i = 0; i < FIR_NBANKS; i++) begin : g_l0
        assign w_l0[i] = SUM_W'($signed(i_d[i]));
    end

    for (genvar i = 0; i < FIR_NBANKS/2; i++) begin : g_l1
        assign w_l1[i] = w_l0[2*i] + w_l0[2*i+1];
    end

    for (genvar i = 0; i < FIR_NBANKS/4; i++) begin : g_l2
        assign w_l2[i] = w_l1[2*i] + w_l1[2*i+1];
    end

    always_ff @(posedge i_clk) begin
        o_sum <= w_l2[0] + w_l2[1];
    end

endmodule

// File: rtl/fir_tap_mac8.sv
// FIR tap MAC over an 8-bank interleaved sample delay line: fetch, rotate, multiply, sum, accumulate.
// Define FIR_SAT_EN to shift and saturate the result to OUT_W bits; otherwise y is the raw accumulator.
module fir_tap_mac8
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int COEF_W = FIR_COEF_W,
    parameter int ACC_W  = FIR_ACC_W
`ifdef FIR_SAT_EN
    ,
    parameter int OUT_W  = FIR_OUT_W,
    parameter int SHIFT  = FIR_SHIFT
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [10:0]       head,
    input  logic [5:0]        nrows,
    output logic              busy,
    input  logic              coef_we,
    input  logic [7:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_d,
    output logic              sram_cen,
    output logic [7:0]        sram_a0,
    output logic [7:0]        sram_a1,
    output logic [7:0]        sram_a2,
    output logic [7:0]        sram_a3,
    output logic [7:0]        sram_a4,
    output logic [7:0]        sram_a5,
    output logic [7:0]        sram_a6,
    output logic [7:0]        sram_a7,
    input  logic [DATA_W-1:0] sram_q0,
    input  logic [DATA_W-1:0] sram_q1,
    input  logic [DATA_W-1:0] sram_q2,
    input  logic [DATA_W-1:0] sram_q3,
    input  logic [DATA_W-1:0] sram_q4,
    input  logic [DATA_W-1:0] sram_q5,
    input  logic [DATA_W-1:0] sram_q6,
    input  logic [DATA_W-1:0] sram_q7,
    output logic [ACC_W-1:0]  y,
    output logic              y_valid,
    input  logic              y_ready
);

    localparam int PROD_W = DATA_W + COEF_W;

    state_t r_state, w_state_nx;

    logic [10:0] r_head;
    logic [5:0]  r_nrows;
    logic [5:0]  r_row;
    logic        w_row_last;
    logic        w_zero;
    logic        w_done;
    logic        w_fin;

    // [0] read in flight, [1] lanes captured, [2] products, [3] tree sum
    logic [FIR_STAGES:0] r_vld_pipe;
    logic [FIR_STAGES:0] r_last_pipe;
    logic [1:0][4:0]     r_row_pipe;

    logic [FIR_NBANKS-1:0][COEF_W-1:0] r_coef [FIR_MAX_ROWS];
    logic [FIR_NBANKS-1:0][DATA_W-1:0] w_q;
    logic [FIR_NBANKS-1:0][7:0]        w_addr;
    logic [FIR_NBANKS-1:0][DATA_W-1:0] r_lane;
    logic [FIR_NBANKS-1:0][PROD_W-1:0] r_prod;

    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_total;
    logic signed [ACC_W-1:0] w_yval;
    logic [ACC_W-1:0]        r_y;
    logic                    r_y_valid;

    assign w_q = {sram_q7, sram_q6, sram_q5, sram_q4, sram_q3, sram_q2, sram_q1, sram_q0};

    assign w_row_last = (r_row == r_nrows - 6'd1);
    assign w_zero     = (r_nrows == 6'd0);
    assign w_done     = r_vld_pipe[FIR_STAGES] && r_last_pipe[FIR_STAGES];
    assign w_fin      = (r_state == DRAIN) && (w_zero || w_done);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:  if (start)      w_state_nx = (nrows == 6'd0) ? DRAIN : FETCH;
            FETCH: if (w_row_last) w_state_nx = DRAIN;
            DRAIN: if (w_fin)      w_state_nx = OUT;
            OUT:   if (y_ready)    w_state_nx = IDLE;
        endcase
    end

    // Addresses are decoded from registered state, so the SRAM samples row r at E(1+r).
    for (genvar b = 0; b < FIR_NBANKS; b++) begin : g_addr
        assign w_addr[b] = (r_state == FETCH) ? bank_addr(r_head, r_row[4:0], 3'(b)) : 8'd0;
    end

    assign sram_cen = (r_state != FETCH);
    assign sram_a0  = w_addr[0];
    assign sram_a1  = w_addr[1];
    assign sram_a2  = w_addr[2];
    assign sram_a3  = w_addr[3];
    assign sram_a4  = w_addr[4];
    assign sram_a5  = w_addr[5];
    assign sram_a6  = w_addr[6];
    assign sram_a7  = w_addr[7];

    always_ff @(posedge clk) begin
        if (coef_we && r_state == IDLE) r_coef[coef_addr[7:3]][coef_addr[2:0]] <= coef_d;
    end

    always_ff @(posedge clk) begin
        r_row_pipe <= {r_row_pipe[0], r_row[4:0]};
    end

    for (genvar j = 0; j < FIR_NBANKS; j++) begin : g_lane
        always_ff @(posedge clk) begin
            if (r_vld_pipe[0]) r_lane[j] <= w_q[r_head[2:0] - 3'(j)];
            if (r_vld_pipe[1]) r_prod[j] <= PROD_W'($signed(r_lane[j]))
                                          * PROD_W'($signed(r_coef[r_row_pipe[1]][j]));
        end
    end

    fir_adder_tree8 #(
        .IN_W  (PROD_W),
        .SUM_W (ACC_W)
    ) u_tree (
        .i_clk (clk),
        .i_d   (r_prod),
        .o_sum (w_sum)
    );

    // The last row bypasses acc and lands straight in y.
    assign w_total = r_acc + w_sum;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_W-1:0] w_shifted;

    always_comb begin
        w_shifted = w_total >>> SHIFT;
        w_yval    = w_shifted;
        if (w_shifted > SAT_MAX)      w_yval = SAT_MAX;
        else if (w_shifted < SAT_MIN) w_yval = SAT_MIN;
    end
`else
    assign w_yval = w_total;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_nrows     <= '0;
            r_row       <= '0;
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
            r_acc       <= '0;
            r_y         <= '0;
            r_y_valid   <= 1'b0;
        end else begin
            r_vld_pipe  <= {r_vld_pipe[FIR_STAGES-1:0], r_state == FETCH};
            r_last_pipe <= {r_last_pipe[FIR_STAGES-1:0], (r_state == FETCH) && w_row_last};

            if (r_state == FETCH) r_row <= r_row + 6'd1;

            if (r_vld_pipe[FIR_STAGES] && !r_last_pipe[FIR_STAGES]) r_acc <= w_total;

            if (r_state == IDLE && start) begin
                r_head  <= head;
                r_nrows <= nrows;
                r_row   <= '0;
                r_acc   <= '0;
            end

            if (w_fin) begin
                r_y       <= w_zero ? '0 : w_yval;
                r_y_valid <= 1'b1;
            end else if (r_state == OUT && y_ready) begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign busy    = (r_state != IDLE);
    assign y       = r_y;
    assign y_valid = r_y_valid;

endmodule

// File: tb/tb_fir_tap_mac8.sv
// Directed bench for fir_tap_mac8 with an SRAM model (bank b, addr a holds a) and a result scoreboard.
module tb_fir_tap_mac8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [10:0]       head = '0;
    logic [5:0]        nrows = '0;
    logic              busy;
    logic              coef_we = 1'b0;
    logic [7:0]        coef_addr = '0;
    logic [15:0]       coef_d = '0;
    logic              sram_cen;
    logic [7:0][7:0]   sa;
    logic [7:0][19:0]  sq = '0;
    logic [47:0]       y;
    logic              y_valid;
    logic              y_ready = 1'b1;

    int                n_cmp = 0;
    int                n_err = 0;
    logic [47:0]       exp_q[$];
    logic [47:0]       last_exp;
    logic signed [15:0] cm [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 8; b++)
            if (!sram_cen) sq[b] <= {12'd0, sa[b]};
    end

    fir_tap_mac8 dut (
        .clk(clk), .rst(rst), .start(start), .head(head), .nrows(nrows), .busy(busy),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_d(coef_d), .sram_cen(sram_cen),
        .sram_a0(sa[0]), .sram_a1(sa[1]), .sram_a2(sa[2]), .sram_a3(sa[3]),
        .sram_a4(sa[4]), .sram_a5(sa[5]), .sram_a6(sa[6]), .sram_a7(sa[7]),
        .sram_q0(sq[0]), .sram_q1(sq[1]), .sram_q2(sq[2]), .sram_q3(sq[3]),
        .sram_q4(sq[4]), .sram_q5(sq[5]), .sram_q6(sq[6]), .sram_q7(sq[7]),
        .y(y), .y_valid(y_valid), .y_ready(y_ready)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] model(input int hd, input int nr);
        longint acc;
        acc = 0;
        for (int t = 0; t < nr * 8; t++)
            acc += longint'(cm[t]) * longint'(((hd - t) & 2047) >> 3);
`ifdef FIR_SAT_EN
        if (acc > 64'sd8388607)       acc = 64'sd8388607;
        else if (acc < -64'sd8388608) acc = -64'sd8388608;
`endif
        return acc[47:0];
    endfunction

    task automatic set_coef(input int t, input logic [15:0] v);
        coef_we   = 1'b1;
        coef_addr = 8'(t);
        coef_d    = v;
        cm[t]     = v;
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic run_job(input string tag, input int hd, input int nr, input int exp_lat,
                           input bit chk_a, input logic [63:0] exp_a);
        int k;
        int cen_cnt;
        logic [47:0] e;
        exp_q.push_back(model(hd, nr));
        head  = 11'(hd);
        nrows = 6'(nr);
        start = 1'b1;
        tick();
        start   = 1'b0;
        coef_we = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        if (chk_a) check({tag, "_addr"}, 64'(sa), exp_a);
        k = 0;
        cen_cnt = 0;
        while (!y_valid && k < 200) begin
            if (!sram_cen) cen_cnt++;
            tick();
            k++;
        end
        check({tag, "_done"}, 64'(y_valid), 64'd1);
        if (exp_lat >= 0) check({tag, "_lat"}, 64'(k), 64'(exp_lat));
        check({tag, "_cen"}, 64'(cen_cnt), 64'(nr));
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = 'x;
        last_exp = e;
        check({tag, "_y"}, 64'(y), 64'(e));
        if (y_ready) begin
            tick();
            check({tag, "_vld_clr"}, 64'(y_valid), 64'd0);
            check({tag, "_idle"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cen", 64'(sram_cen), 64'd1);
        check("rst_addr", 64'(sa), 64'd0);
        check("rst_yv", 64'(y_valid), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        rst = 1'b0;
        tick();

        for (int t = 0; t < 256; t++) set_coef(t, 16'd1);
        run_job("t1", 15, 1, 5, 1'b1, 64'h0101010101010101);
        run_job("t2", 3, 1, 5, 1'b1, 64'hFFFFFFFF00000000);

        for (int t = 0; t < 256; t++) set_coef(t, (t == 0) ? 16'd1 : 16'd0);
        run_job("t3", 100, 32, 36, 1'b0, 64'd0);

        // Consumer stalls: result holds, start and coef writes are dropped while busy.
        y_ready = 1'b0;
        run_job("t4", 500, 2, 6, 1'b0, 64'd0);
        for (int i = 0; i < 10; i++) begin
            start = 1'b1; head = 11'd5; nrows = 6'd3;
            coef_we = 1'b1; coef_addr = 8'd0; coef_d = 16'h7777;
            tick();
            check("t4_hold_vld", 64'(y_valid), 64'd1);
            check("t4_hold_y", 64'(y), 64'(last_exp));
        end
        start = 1'b0; coef_we = 1'b0; y_ready = 1'b1;
        tick();
        check("t4_vld_clr", 64'(y_valid), 64'd0);
        tick();
        check("t4_no_restart", 64'(busy), 64'd0);
        run_job("t4b", 500, 2, 6, 1'b0, 64'd0);

        // Reset sampled at E3 of an 8-row job.
        head = 11'd700; nrows = 6'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_cen", 64'(sram_cen), 64'd1);
        check("t5_yv", 64'(y_valid), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (y_valid) seen = 1'b1;
            tick();
        end
        check("t5_no_result", 64'(seen), 64'd0);
        run_job("t5b", 700, 8, 12, 1'b0, 64'd0);

        for (int t = 0; t < 256; t++) set_coef(t, 16'($urandom_range(0, 65535)));
        for (int n = 0; n < 4; n++) begin
            int hd, nr;
            hd = int'($urandom_range(0, 2047));
            nr = int'($urandom_range(1, 32));
            run_job("rnd", hd, nr, nr + 4, 1'b0, 64'd0);
        end

        // Coefficient write in the same cycle as start must be seen by the job.
        coef_we = 1'b1; coef_addr = 8'd3; coef_d = 16'hFB2E; cm[3] = 16'hFB2E;
        run_job("cw_start", 2000, 4, 8, 1'b0, 64'd0);

        run_job("zero", 123, 0, 1, 1'b0, 64'd0);

        for (int t = 0; t < 256; t++) set_coef(t, 16'd32767);
        run_job("t6", 2047, 32, 36, 1'b0, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
